mmu_io_ctrl: RTL and testbench

MMU_IO_CTRL -- requirements
Module: mmu_io_ctrl

---
 rtl/mmu_io_ctrl_if.sv | 28 ++
 rtl/mmu_io_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mmu_io_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_io_ctrl_if.sv
// rtl/mmu_io_ctrl_if.sv - Z80 CPU-side and MMU-side signal bundle for mmu_io_ctrl
interface mmu_io_ctrl_if;
    logic        n_iorq;
    logic        n_rd;
    logic        n_wr;
    logic        n_m1;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        page_en_wr_en;
    logic        reg_file_wr_en;
    logic        reg_file_rd_en;
    logic [1:0]  mmu_addr;
    logic [7:0]  mmu_data;
    logic        n_wait;
    logic        cpu_din_oe;

    modport slave (
        input  n_iorq, n_rd, n_wr, n_m1, cpu_addr, cpu_dout,
        output page_en_wr_en, reg_file_wr_en, reg_file_rd_en,
               mmu_addr, mmu_data, n_wait, cpu_din_oe
    );

    modport master (
        output n_iorq, n_rd, n_wr, n_m1, cpu_addr, cpu_dout,
        input  page_en_wr_en, reg_file_wr_en, reg_file_rd_en,
               mmu_addr, mmu_data, n_wait, cpu_din_oe
    );
endinterface

// File: rtl/mmu_io_ctrl.sv
// rtl/mmu_io_ctrl.sv - Z80 I/O port decode and MMU write/readback sequencer; readback built only with MMU_IO_READBACK_EN
module mmu_io_ctrl #(
    parameter logic [7:0] IO_BASE     = 8'h78,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          n_reset,
    mmu_io_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, STROBE, HOLD
`ifdef MMU_IO_READBACK_EN
        , RD_WAIT, RD_HOLD
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] iorq_sq, rd_sq, wr_sq;
    logic       armed_q;
    logic       page_q, page_d;
    logic       regwr_q, regwr_d;
    logic       is_page_q, is_page_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
`ifdef MMU_IO_READBACK_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    logic       rd_en_q, rd_en_d;
    logic       oe_q, oe_d;
    logic       n_wait_q, n_wait_d;
    logic [3:0] cnt_q, cnt_d;
`endif

    logic       iorq_s, rd_s, wr_s;
    logic [7:0] port_off;
    logic       in_win, is_bank;
    logic       unused_addr_hi;

    assign iorq_s         = iorq_sq[1];
    assign rd_s           = rd_sq[1];
    assign wr_s           = wr_sq[1];
    assign port_off       = bus.cpu_addr[7:0] - IO_BASE;
    assign in_win         = port_off < 8'd5;
    assign is_bank        = port_off < 8'd4;
    assign unused_addr_hi = ^bus.cpu_addr[15:8];

    // armed_q keeps WAIT_IDLE from trusting the reset value of the synchronizer
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            iorq_sq <= 2'b11;
            rd_sq   <= 2'b11;
            wr_sq   <= 2'b11;
            armed_q <= 1'b0;
        end else begin
            iorq_sq <= {iorq_sq[0], bus.n_iorq};
            rd_sq   <= {rd_sq[0], bus.n_rd};
            wr_sq   <= {wr_sq[0], bus.n_wr};
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= WAIT_IDLE;
            page_q    <= 1'b0;
            regwr_q   <= 1'b0;
            is_page_q <= 1'b0;
            addr_q    <= 2'b00;
            data_q    <= 8'h00;
`ifdef MMU_IO_READBACK_EN
            rd_en_q   <= 1'b0;
            oe_q      <= 1'b0;
            n_wait_q  <= 1'b1;
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            regwr_q   <= regwr_d;
            is_page_q <= is_page_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef MMU_IO_READBACK_EN
            rd_en_q   <= rd_en_d;
            oe_q      <= oe_d;
            n_wait_q  <= n_wait_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        page_d    = 1'b0;
        regwr_d   = 1'b0;
        is_page_d = is_page_q;
        addr_d    = addr_q;
        data_d    = data_q;
`ifdef MMU_IO_READBACK_EN
        rd_en_d   = rd_en_q;
        oe_d      = oe_q;
        n_wait_d  = n_wait_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            WAIT_IDLE: begin
                if (armed_q && iorq_sq == 2'b11) state_d = IDLE;
            end
            IDLE: begin
                if (!iorq_s) begin
                    if (!bus.n_m1) begin
                        state_d = HOLD;
                    end else if (!rd_s && !wr_s) begin
                        state_d = HOLD;
                    end else if (!wr_s) begin
                        if (in_win) begin
                            addr_d    = bus.cpu_addr[1:0];
                            data_d    = bus.cpu_dout;
                            is_page_d = !is_bank;
                            state_d   = STROBE;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (!rd_s) begin
`ifdef MMU_IO_READBACK_EN
                        if (is_bank) begin
                            addr_d   = bus.cpu_addr[1:0];
                            rd_en_d  = 1'b1;
                            oe_d     = 1'b1;
                            n_wait_d = 1'b0;
                            cnt_d    = WAIT_LOAD;
                            state_d  = RD_WAIT;
                        end else begin
                            state_d = HOLD;
                        end
`else
                        state_d = HOLD;
`endif
                    end
                end
            end
            STROBE: begin
                page_d  = is_page_q;
                regwr_d = !is_page_q;
                state_d = HOLD;
            end
            HOLD: begin
                if (iorq_s) state_d = IDLE;
            end
`ifdef MMU_IO_READBACK_EN
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    n_wait_d = 1'b1;
                    state_d  = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (iorq_s) begin
                    rd_en_d = 1'b0;
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign bus.page_en_wr_en  = page_q;
    assign bus.reg_file_wr_en = regwr_q;
    assign bus.mmu_addr       = addr_q;
    assign bus.mmu_data       = data_q;
`ifdef MMU_IO_READBACK_EN
    assign bus.reg_file_rd_en = rd_en_q;
    assign bus.cpu_din_oe     = oe_q;
    assign bus.n_wait         = n_wait_q;
`else
    assign bus.reg_file_rd_en = 1'b0;
    assign bus.cpu_din_oe     = 1'b0;
    assign bus.n_wait         = 1'b1;
`endif

endmodule

// File: tb/tb_mmu_io_ctrl.sv
// tb/tb_mmu_io_ctrl.sv - bench for mmu_io_ctrl: directed vector table, reset corner cases, random CPU cycles vs. transaction model
module tb_mmu_io_ctrl;

    localparam int         W    = 2;
    localparam logic [7:0] BASE = 8'h78;
`ifdef MMU_IO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    localparam int K_OUT = 0, K_IN = 1, K_ACK = 2, K_BOTH = 3;

    typedef struct {
        int         kind;
        logic [7:0] port;
        logic [7:0] data;
        int         hold;
        int         e_page;
        int         e_reg;
        int         e_wait;
        int         e_rd;
        logic [1:0] e_addr;
        logic [7:0] e_data;
    } vec_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   edge_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    mmu_io_ctrl_if bus();

    mmu_io_ctrl #(.IO_BASE(BASE), .WAIT_CYCLES(W)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int c_page, c_reg, c_wait, c_rd, c_oe, c_both, first_off, k_ref;
    logic [1:0] m_addr;
    logic [7:0] m_data;

    task automatic check(input string tag, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%0h expected=%0h", tag, field, act, exp);
        end
    endtask

    task automatic clear_counts();
        c_page = 0; c_reg = 0; c_wait = 0; c_rd = 0; c_oe = 0; c_both = 0;
        first_off = -1;
    endtask

    task automatic sample();
        if (bus.page_en_wr_en === 1'b1) c_page++;
        if (bus.reg_file_wr_en === 1'b1) c_reg++;
        if (bus.n_wait !== 1'b1) c_wait++;
        if (bus.reg_file_rd_en === 1'b1) c_rd++;
        if (bus.cpu_din_oe === 1'b1) c_oe++;
        if (bus.page_en_wr_en === 1'b1 && bus.reg_file_wr_en === 1'b1) c_both++;
        if ((bus.page_en_wr_en === 1'b1 || bus.reg_file_wr_en === 1'b1) && first_off < 0)
            first_off = edge_n - k_ref;
    endtask

    task automatic bus_idle();
        bus.n_iorq = 1'b1;
        bus.n_rd   = 1'b1;
        bus.n_wr   = 1'b1;
        bus.n_m1   = 1'b1;
    endtask

    // Transaction-level model: what one CPU I/O cycle should leave behind.
    function automatic vec_t model(input int kind, input logic [7:0] port,
                                   input logic [7:0] data, input int hold);
        vec_t v;
        logic [7:0] off;
        off = port - BASE;
        v.kind = kind; v.port = port; v.data = data; v.hold = hold;
        v.e_page = 0; v.e_reg = 0; v.e_wait = 0; v.e_rd = 0;
        if (kind == K_OUT && off <= 8'd4) begin
            m_data = data;
            m_addr = port[1:0];
            if (off == 8'd4) v.e_page = 1;
            else             v.e_reg  = 1;
        end else if (kind == K_IN && RB && off < 8'd4) begin
            m_addr = port[1:0];
            v.e_wait = W;
            v.e_rd   = hold;
        end
        v.e_addr = m_addr;
        v.e_data = m_data;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        clear_counts();
        @(negedge clk);
        bus.cpu_addr = {8'($urandom), v.port};
        bus.cpu_dout = (v.kind == K_OUT) ? v.data : 8'($urandom);
        bus.n_m1     = (v.kind == K_ACK) ? 1'b0 : 1'b1;
        bus.n_rd     = (v.kind == K_IN || v.kind == K_BOTH) ? 1'b0 : 1'b1;
        bus.n_wr     = (v.kind == K_OUT || v.kind == K_BOTH) ? 1'b0 : 1'b1;
        bus.n_iorq   = 1'b0;
        k_ref        = edge_n + 1;
        repeat (v.hold) begin
            @(posedge clk); #1; sample();
        end
        @(negedge clk);
        bus_idle();
        repeat (6) begin
            @(posedge clk); #1; sample();
        end
        check(tag, "page_pulses", c_page, v.e_page);
        check(tag, "reg_pulses", c_reg, v.e_reg);
        check(tag, "wait_low_clks", c_wait, v.e_wait);
        check(tag, "rd_en_clks", c_rd, v.e_rd);
        check(tag, "din_oe_clks", c_oe, v.e_rd);
        check(tag, "pulse_overlap", c_both, 0);
        check(tag, "mmu_addr", bus.mmu_addr, v.e_addr);
        check(tag, "mmu_data", bus.mmu_data, v.e_data);
        if (v.e_page + v.e_reg > 0) check(tag, "pulse_latency", first_off, 3);
    endtask

    vec_t tbl[13];

    initial begin
        int r;
        int kind;
        int hold;
        logic [7:0] port;

        tbl = '{
            '{K_OUT,  8'h7C, 8'h01, 5,  1, 0, 0,          0,          2'd0,                8'h01},
            '{K_OUT,  8'h7A, 8'h5A, 20, 0, 1, 0,          0,          2'd2,                8'h5A},
            '{K_IN,   8'h79, 8'h00, 6,  0, 0, RB ? W : 0, RB ? 6 : 0, RB ? 2'd1 : 2'd2,    8'h5A},
            '{K_OUT,  8'h80, 8'hFF, 5,  0, 0, 0,          0,          RB ? 2'd1 : 2'd2,    8'h5A},
            '{K_IN,   8'h7C, 8'h00, 5,  0, 0, 0,          0,          RB ? 2'd1 : 2'd2,    8'h5A},
            '{K_ACK,  8'h7A, 8'h33, 5,  0, 0, 0,          0,          RB ? 2'd1 : 2'd2,    8'h5A},
            '{K_IN,   8'h78, 8'h00, 5,  0, 0, RB ? W : 0, RB ? 5 : 0, RB ? 2'd0 : 2'd2,    8'h5A},
            '{K_OUT,  8'h78, 8'h03, 5,  0, 1, 0,          0,          2'd0,                8'h03},
            '{K_BOTH, 8'h79, 8'h44, 5,  0, 0, 0,          0,          2'd0,                8'h03},
            '{K_OUT,  8'h7B, 8'hC3, 3,  0, 1, 0,          0,          2'd3,                8'hC3},
            '{K_OUT,  8'h77, 8'h11, 4,  0, 0, 0,          0,          2'd3,                8'hC3},
            '{K_OUT,  8'h7D, 8'h22, 4,  0, 0, 0,          0,          2'd3,                8'hC3},
            '{K_OUT,  8'h7C, 8'hE7, 2,  1, 0, 0,          0,          2'd0,                8'hE7}
        };

        bus_idle();
        bus.cpu_addr = 16'h0000;
        bus.cpu_dout = 8'h00;
        clear_counts();
        k_ref = 0;

        #23;
        check("reset", "page_en_wr_en", bus.page_en_wr_en, 1'b0);
        check("reset", "reg_file_wr_en", bus.reg_file_wr_en, 1'b0);
        check("reset", "reg_file_rd_en", bus.reg_file_rd_en, 1'b0);
        check("reset", "cpu_din_oe", bus.cpu_din_oe, 1'b0);
        check("reset", "n_wait", bus.n_wait, 1'b1);
        check("reset", "mmu_addr", bus.mmu_addr, 2'd0);
        check("reset", "mmu_data", bus.mmu_data, 8'h00);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset lands mid read cycle with IORQ still low; the stale cycle must be ignored.
        clear_counts();
        @(negedge clk);
        bus.cpu_addr = 16'h1279;
        bus.n_iorq   = 1'b0;
        bus.n_rd     = 1'b0;
        k_ref        = edge_n + 1;
        repeat (3) begin
            @(posedge clk); #1; sample();
        end
        check("rst_mid", "n_wait_before", bus.n_wait, RB ? 1'b0 : 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        check("rst_mid", "n_wait_async", bus.n_wait, 1'b1);
        check("rst_mid", "rd_en_async", bus.reg_file_rd_en, 1'b0);
        check("rst_mid", "din_oe_async", bus.cpu_din_oe, 1'b0);
        @(negedge clk);
        n_reset = 1'b1;
        clear_counts();
        repeat (8) begin
            @(posedge clk); #1; sample();
        end
        check("rst_mid", "pulses_while_stale", c_page + c_reg, 0);
        check("rst_mid", "wait_while_stale", c_wait, 0);
        check("rst_mid", "rd_en_while_stale", c_rd, 0);
        @(negedge clk);
        bus_idle();
        repeat (4) @(negedge clk);
        m_addr = 2'd0;
        m_data = 8'h00;
        run_vec(model(K_OUT, 8'h7B, 8'hA5, 4), "rst_mid_next");

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            kind = (r < 5) ? K_OUT : (r < 8) ? K_IN : (r == 8) ? K_ACK : K_BOTH;
            port = ($urandom_range(0, 9) < 7) ? 8'(8'h76 + $urandom_range(0, 8)) : 8'($urandom);
            hold = (kind == K_IN) ? int'($urandom_range(W + 1, 8)) : int'($urandom_range(1, 6));
            run_vec(model(kind, port, 8'($urandom), hold), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
